// File: rtl/flash_byte_read_responder.sv
// flash_byte_read_responder
// Responder end of the start/arguments/finished handshake. One accepted
// start performs a single Avalon-MM pipelined read of a 32-bit flash word.
// The byte addressed by the two low argument bits is then returned on
// data_out, together with a one-cycle finished pulse.
module flash_byte_read_responder #(
  parameter int N        = 32,
  parameter int M        = 8,
  parameter int FLASH_AW = 23
) (
  input  logic                sm_clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N-1:0]        arguments,
  output logic                finished,
  output logic [M-1:0]        data_out,
  output logic                busy,
  output logic [FLASH_AW-1:0] flash_address,
  output logic                flash_read,
  output logic [3:0]          flash_byteenable,
  input  logic                flash_waitrequest,
  input  logic [31:0]         flash_readdata,
  input  logic                flash_readdatavalid
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_VALID = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t     state_reg;
  logic [1:0] lane_reg;    // byte lane within the word, latched at start
  logic [7:0] lanes [4];   // readdata split into its four byte lanes

  // Whole-word reads only; the byte is picked out internally.
  assign flash_byteenable = 4'b1111;

  // Slice the read data word into byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = flash_readdata[8*gi +: 8];
  end

  // Argument bits above the byte address carry no meaning here.
  if (N > FLASH_AW + 2) begin : g_unused_args
    logic unused_high_args;
    assign unused_high_args = ^arguments[N-1:FLASH_AW+2];
  end

  // Request sequencing: latch address, issue one read, capture one byte.
  always_ff @(posedge sm_clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      lane_reg      <= 2'd0;
      finished      <= 1'b0;
      busy          <= 1'b0;
      flash_read    <= 1'b0;
      flash_address <= '0;
      data_out      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          finished <= 1'b0;
          if (start) begin
            lane_reg      <= arguments[1:0];
            flash_address <= arguments[FLASH_AW+1:2];
            flash_read    <= 1'b1;
            busy          <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          // Command and address stay put until the slave stops stalling.
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            state_reg  <= WAIT_VALID;
          end
        end
        WAIT_VALID: begin
          if (flash_readdatavalid) begin
            data_out  <= M'(lanes[lane_reg]);
            finished  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // busy covers the finished cycle, so a start here is dropped.
          finished  <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          finished   <= 1'b0;
          busy       <= 1'b0;
          flash_read <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_byte_read_responder.sv
// Bench for flash_byte_read_responder: the bench acts as the flash slave.
// Expected bytes are queued when a start is driven and checked when finished rises.
module tb_flash_byte_read_responder;

  logic        sm_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] arguments = '0;
  logic        finished;
  logic [7:0]  data_out;
  logic        busy;
  logic [22:0] flash_address;
  logic        flash_read;
  logic [3:0]  flash_byteenable;
  logic        flash_waitrequest = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  last_byte = 8'h00;

  flash_byte_read_responder #(.N(32), .M(8), .FLASH_AW(23)) dut (
    .sm_clk              (sm_clk),
    .reset               (reset),
    .start               (start),
    .arguments           (arguments),
    .finished            (finished),
    .data_out            (data_out),
    .busy                (busy),
    .flash_address       (flash_address),
    .flash_read          (flash_read),
    .flash_byteenable    (flash_byteenable),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid)
  );

  always #5 sm_clk = ~sm_clk;

  // Scoreboard: every finished pulse must match the oldest queued byte.
  always @(negedge sm_clk) begin
    if (finished === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected_finished data_out=%h (no request outstanding)", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL scoreboard_data got=%h expected=%h", data_out, e);
        end else begin
          $display("txn result data_out=%h ok", data_out);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sm_clk);
    #1;
  endtask

  // One full request; returns in the DONE cycle with latency counted from the start cycle (inclusive).
  task automatic do_read(input logic [31:0] args, input logic [31:0] word,
                         input int stalls, input bit collide, output int lat);
    int          cmds;
    int          stall_left;
    bit          valid_next;
    logic [1:0]  ln;
    logic [7:0]  exp_b;
    logic [22:0] exp_a;
    ln         = args[1:0];
    exp_a      = args[24:2];
    exp_b      = 8'(word >> (8 * ln));
    cmds       = 0;
    stall_left = stalls;
    valid_next = 1'b0;
    exp_q.push_back(exp_b);
    $display("txn start args=%h word=%h stalls=%0d collide=%0d expect=%h", args, word, stalls, collide, exp_b);
    start     = 1'b1;
    arguments = args;
    tick();
    start     = 1'b0;
    arguments = $urandom;
    lat = 2;
    while (finished !== 1'b1 && lat < 40) begin
      flash_readdatavalid = valid_next;
      flash_readdata      = valid_next ? word : $urandom;
      valid_next          = 1'b0;
      if (collide && flash_readdatavalid) begin
        start     = 1'b1;
        arguments = 32'h0000_0008;
      end
      if (flash_read === 1'b1) begin
        checks++;
        if (flash_address !== exp_a) begin
          errors++;
          $display("FAIL flash_address got=%h expected=%h", flash_address, exp_a);
        end
        if (stall_left > 0) begin
          flash_waitrequest = 1'b1;
          stall_left--;
        end else begin
          flash_waitrequest = 1'b0;
          cmds++;
          valid_next = 1'b1;
        end
      end else begin
        flash_waitrequest = 1'b0;
      end
      tick();
      lat++;
      start               = 1'b0;
      flash_readdatavalid = 1'b0;
      flash_waitrequest   = 1'b0;
    end
    checks++;
    if (finished !== 1'b1) begin
      errors++;
      $display("FAIL finished_timeout got=%b expected=1 after %0d cycles", finished, lat);
      void'(exp_q.pop_front());
    end
    checks++;
    if (lat != stalls + 4) begin
      errors++;
      $display("FAIL latency got=%0d expected=%0d", lat, stalls + 4);
    end
    checks++;
    if (cmds != 1) begin
      errors++;
      $display("FAIL command_count got=%0d expected=1", cmds);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_done got=%b expected=1", busy);
    end
    last_byte = exp_b;
  endtask

  // Quiet cycles: nothing may move while the responder is idle.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (finished !== 1'b0 || busy !== 1'b0 || flash_read !== 1'b0 || data_out !== last_byte) begin
        errors++;
        $display("FAIL idle fin=%b busy=%b rd=%b data=%h expected 0/0/0/%h",
                 finished, busy, flash_read, data_out, last_byte);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (finished !== 1'b0 || busy !== 1'b0 || flash_read !== 1'b0 ||
        flash_address !== 23'h0 || data_out !== 8'h00 || flash_byteenable !== 4'hF) begin
      errors++;
      $display("FAIL reset_state fin=%b busy=%b rd=%b addr=%h data=%h be=%h expected 0/0/0/0/00/f",
               finished, busy, flash_read, flash_address, data_out, flash_byteenable);
    end
    reset = 1'b0;
    $display("txn reset released");
    idle_cycles(2);
  endtask

  task automatic test_basic();
    int lat;
    do_read(32'h0000_0106, 32'hA1B2_C3D4, 0, 1'b0, lat);
    idle_cycles(2);
  endtask

  task automatic test_all_lanes();
    int lat;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'h40 + 32'(i);
      do_read(a, 32'h1122_3344, 0, 1'b0, lat);
      idle_cycles(1);
    end
  endtask

  task automatic test_stall();
    int lat;
    do_read(32'h0000_0106, 32'hA1B2_C3D4, 3, 1'b0, lat);
    idle_cycles(2);
  endtask

  task automatic test_busy_collision();
    int lat;
    do_read(32'hFF00_0105, 32'h9988_7766, 0, 1'b1, lat);
    idle_cycles(4);
  endtask

  task automatic test_reset_mid();
    int lat;
    start     = 1'b1;
    arguments = 32'h0000_0105;
    tick();
    start     = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (finished !== 1'b0 || busy !== 1'b0 || flash_read !== 1'b0 ||
        flash_address !== 23'h0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid fin=%b busy=%b rd=%b addr=%h data=%h expected all zero",
               finished, busy, flash_read, flash_address, data_out);
    end
    last_byte = 8'h00;
    $display("txn reset asserted mid-operation");
    @(posedge sm_clk);
    #1;
    reset = 1'b0;
    idle_cycles(3);
    do_read(32'h0000_0003, 32'h5A6B_7C8D, 0, 1'b0, lat);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    int lat;
    flash_readdatavalid = 1'b1;
    flash_readdata      = 32'hFFFF_FFFF;
    tick();
    flash_readdatavalid = 1'b0;
    checks++;
    if (data_out !== last_byte || finished !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_valid data=%h fin=%b busy=%b expected %h/0/0", data_out, finished, busy, last_byte);
    end
    $display("txn stray readdatavalid in idle");
    do_read(32'h0000_020A, 32'hCAFE_F00D, 0, 1'b0, lat);
    // Start during the finished cycle is dropped.
    start     = 1'b1;
    arguments = 32'h0000_0001;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || flash_read !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done busy=%b rd=%b expected 0/0", busy, flash_read);
    end
    do_read(32'h0000_0007, 32'h0123_4567, 0, 1'b0, lat);
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_lanes();
    test_stall();
    test_busy_collision();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
